// File: rtl/payload_forwarder_if.sv
// payload_forwarder_if: ingress byte stream plus egress valid/ready stream of the payload forwarder.
interface payload_forwarder_if;
    logic [7:0] data_in;
    logic       data_valid_in;
    logic       last_in;
    logic       fwd_enable;
    logic       drop_enable;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_err;
    logic       m_ready;
    modport master (
        output data_in, data_valid_in, last_in, fwd_enable, drop_enable, m_ready,
        input  m_data, m_valid, m_last, m_err
    );
    modport slave (
        input  data_in, data_valid_in, last_in, fwd_enable, drop_enable, m_ready,
        output m_data, m_valid, m_last, m_err
    );
endinterface

// File: rtl/payload_forwarder.sv
// payload_forwarder: forwards payload bytes through a FIFO, truncating overflowed packets with an error marker.
// Define FWD_STATS_EN to add saturating packet/byte statistics outputs.
module payload_forwarder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    payload_forwarder_if.slave   bus,
    output logic                 overflow
`ifdef FWD_STATS_EN
    ,
    output logic [15:0]          fwd_pkt_count,
    output logic [15:0]          drop_pkt_count,
    output logic [31:0]          fwd_byte_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {PASS, TRUNC, MARK} state_t;
    state_t     r_state;
    logic       r_overflow;
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic [9:0] r_mem [FIFO_DEPTH];
    logic       w_empty, w_full, w_pop, w_can, w_push_cond, w_push;
    logic [9:0] w_wdata, w_head;
    assign w_empty     = r_wr_ptr == r_rd_ptr;
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop       = !w_empty && bus.m_ready;
    assign w_can       = !w_full || w_pop;
    assign w_push_cond = bus.data_valid_in && bus.fwd_enable && !bus.drop_enable;
    assign w_push      = (r_state == PASS && w_push_cond && w_can) || (r_state == MARK && w_can);
    assign w_wdata     = (r_state == MARK) ? 10'h300 : {1'b0, bus.last_in, bus.data_in};
    assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
    assign bus.m_valid = !w_empty;
    assign bus.m_data  = w_empty ? 8'h00 : w_head[7:0];
    assign bus.m_last  = !w_empty && w_head[8];
    assign bus.m_err   = !w_empty && w_head[9];
    assign overflow    = r_overflow;
    // Storage is left unreset; the pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= PASS;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                PASS: if (w_push_cond && !w_can) begin
                    r_overflow <= 1'b1;
                    r_state    <= bus.last_in ? MARK : TRUNC;
                end
                TRUNC: if (bus.data_valid_in && bus.last_in) r_state <= MARK;
                MARK: begin
                    if (bus.data_valid_in) r_overflow <= 1'b1;
                    if (w_can) r_state <= PASS;
                end
                default: r_state <= PASS;
            endcase
        end
    end
`ifdef FWD_STATS_EN
    logic [15:0] r_fwd_pkt, r_drop_pkt;
    logic [31:0] r_fwd_byte;
    assign fwd_pkt_count  = r_fwd_pkt;
    assign drop_pkt_count = r_drop_pkt;
    assign fwd_byte_count = r_fwd_byte;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_pkt  <= '0;
            r_drop_pkt <= '0;
            r_fwd_byte <= '0;
        end else begin
            if (w_push && w_wdata[8] && r_fwd_pkt != '1) r_fwd_pkt <= r_fwd_pkt + 1'b1;
            if (w_push && !w_wdata[9] && r_fwd_byte != '1) r_fwd_byte <= r_fwd_byte + 1'b1;
            if (bus.data_valid_in && bus.last_in && bus.drop_enable && r_drop_pkt != '1)
                r_drop_pkt <= r_drop_pkt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_payload_forwarder.sv
// tb_payload_forwarder: table-driven vectors plus directed overflow, full-with-pop and reset sequences.
module tb_payload_forwarder;
    logic clk, rst_n, overflow;
`ifdef FWD_STATS_EN
    logic [15:0] fwd_pkt_count, drop_pkt_count;
    logic [31:0] fwd_byte_count;
`endif
    payload_forwarder_if bus();
    payload_forwarder #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .overflow(overflow)
`ifdef FWD_STATS_EN
        , .fwd_pkt_count(fwd_pkt_count), .drop_pkt_count(drop_pkt_count), .fwd_byte_count(fwd_byte_count)
`endif
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    typedef struct {
        logic vld, lst, fwd, drp;
        logic [7:0] d;
        logic rdy;
        logic e_vld;
        logic [7:0] e_d;
        logic e_lst, e_err, e_ovf;
    } vec_t;
    vec_t tbl[14];
    int n_chk = 0;
    int n_fail = 0;
    logic [9:0] exp_q[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic drv(input logic v, input logic l, input logic f, input logic dr, input logic [7:0] d, input logic r);
        bus.data_valid_in = v;
        bus.last_in       = l;
        bus.fwd_enable    = f;
        bus.drop_enable   = dr;
        bus.data_in       = d;
        bus.m_ready       = r;
    endtask
    task automatic drain(input string name);
        logic [9:0] e;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            #1;
            if (bus.m_valid) begin
                e = exp_q.pop_front();
                chk(name, {22'd0, bus.m_err, bus.m_last, bus.m_data}, {22'd0, e});
            end
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d entries left expected 0", name, exp_q.size());
            exp_q.delete();
        end
        #1;
        chk({name, "_empty"}, {31'd0, bus.m_valid}, 32'd0);
        bus.m_ready = 1'b0;
    endtask
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_m_last_err", {30'd0, bus.m_last, bus.m_err}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
    initial begin
        tbl[0]  = '{1,0,1,0,8'h11,1, 0,8'h00,0,0,0};
        tbl[1]  = '{1,0,1,0,8'h12,1, 1,8'h11,0,0,0};
        tbl[2]  = '{1,0,1,0,8'h13,1, 1,8'h12,0,0,0};
        tbl[3]  = '{1,0,1,0,8'h14,1, 1,8'h13,0,0,0};
        tbl[4]  = '{1,1,1,0,8'h15,1, 1,8'h14,0,0,0};
        tbl[5]  = '{0,0,0,0,8'h00,1, 1,8'h15,1,0,0};
        tbl[6]  = '{0,0,0,0,8'h00,1, 0,8'h00,0,0,0};
        tbl[7]  = '{1,0,1,1,8'hA1,1, 0,8'h00,0,0,0};
        tbl[8]  = '{1,0,1,1,8'hA2,1, 0,8'h00,0,0,0};
        tbl[9]  = '{1,0,1,1,8'hA3,1, 0,8'h00,0,0,0};
        tbl[10] = '{1,1,1,1,8'hA4,1, 0,8'h00,0,0,0};
        tbl[11] = '{0,0,0,0,8'h00,1, 0,8'h00,0,0,0};
        tbl[12] = '{1,1,0,0,8'hB1,1, 0,8'h00,0,0,0};
        tbl[13] = '{0,0,0,0,8'h00,1, 0,8'h00,0,0,0};
        rst_n = 1'b0;
        drv(0,0,0,0,8'h00,0);
        repeat (2) @(negedge clk);
        chk("reset_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            drv(tbl[i].vld, tbl[i].lst, tbl[i].fwd, tbl[i].drp, tbl[i].d, tbl[i].rdy);
            #1;
            chk($sformatf("vec%0d_valid", i), {31'd0, bus.m_valid}, {31'd0, tbl[i].e_vld});
            if (tbl[i].e_vld) begin
                chk($sformatf("vec%0d_data", i), {24'd0, bus.m_data}, {24'd0, tbl[i].e_d});
                chk($sformatf("vec%0d_last", i), {31'd0, bus.m_last}, {31'd0, tbl[i].e_lst});
                chk($sformatf("vec%0d_err", i), {31'd0, bus.m_err}, {31'd0, tbl[i].e_err});
            end
            chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, tbl[i].e_ovf});
            @(negedge clk);
        end
`ifdef FWD_STATS_EN
        chk("stats_drop_pkt", {16'd0, drop_pkt_count}, 32'd1);
        chk("stats_fwd_pkt", {16'd0, fwd_pkt_count}, 32'd1);
        chk("stats_fwd_byte", fwd_byte_count, 32'd5);
`endif
        // 10-byte packet into an 8-deep FIFO with the sink stalled
        for (int i = 0; i < 10; i++) begin
            drv(1, i == 9, 1, 0, 8'h20 + 8'(i), 0);
            @(negedge clk);
        end
        drv(0,0,0,0,8'h00,0);
        #1;
        chk("ovf_overflow", {31'd0, overflow}, 32'd1);
        chk("ovf_head", {24'd0, bus.m_data}, 32'h20);
        for (int i = 0; i < 8; i++) exp_q.push_back({2'b00, 8'h20 + 8'(i)});
        exp_q.push_back(10'h300);
        drain("ovf_drain");
`ifdef FWD_STATS_EN
        chk("ovf_fwd_pkt", {16'd0, fwd_pkt_count}, 32'd2);
        chk("ovf_fwd_byte", fwd_byte_count, 32'd13);
`endif
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            drv(1, 0, 1, 0, 8'h40 + 8'(i), 0);
            @(negedge clk);
        end
        drv(1, 1, 1, 0, 8'h48, 1);
        #1;
        chk("full_pop_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("full_pop_head", {24'd0, bus.m_data}, 32'h40);
        @(negedge clk);
        drv(0,0,0,0,8'h00,0);
        #1;
        chk("full_pop_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 1; i < 8; i++) exp_q.push_back({2'b00, 8'h40 + 8'(i)});
        exp_q.push_back({2'b01, 8'h48});
        drain("full_pop_drain");
`ifdef FWD_STATS_EN
        chk("full_pop_fwd_byte", fwd_byte_count, 32'd9);
`endif
        for (int i = 0; i < 3; i++) begin
            drv(1, 0, 1, 0, 8'h50 + 8'(i), 0);
            @(negedge clk);
        end
        drv(0,0,0,0,8'h00,0);
        #1;
        chk("pre_rst_valid", {31'd0, bus.m_valid}, 32'd1);
        pulse_reset();
        drv(1, 0, 1, 0, 8'h61, 0);
        @(negedge clk);
        drv(1, 1, 1, 0, 8'h62, 0);
        @(negedge clk);
        drv(0,0,0,0,8'h00,0);
        exp_q.push_back({2'b00, 8'h61});
        exp_q.push_back({2'b01, 8'h62});
        drain("post_rst_drain");
        chk("post_rst_ovf", {31'd0, overflow}, 32'd0);
`ifdef FWD_STATS_EN
        chk("post_rst_fwd_pkt", {16'd0, fwd_pkt_count}, 32'd1);
        chk("post_rst_fwd_byte", fwd_byte_count, 32'd2);
        chk("post_rst_drop_pkt", {16'd0, drop_pkt_count}, 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/payload_forwarder.md
PAYLOAD_FORWARDER -- requirements
Module: payload_forwarder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, output FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 data_in  input  8  packet byte from the ingress stream.
REQ-005 data_valid_in  input  1  data_in valid this cycle; there is no upstream backpressure.
REQ-006 last_in  input  1  final byte of packet, qualified by data_valid_in.
REQ-007 fwd_enable  input  1  from control FSM: current byte is payload to forward.
REQ-008 drop_enable  input  1  from control FSM: current byte is payload to discard.
REQ-009 m_data  output  8  egress byte at FIFO head.
REQ-010 m_valid  output  1  egress byte available.
REQ-011 m_last  output  1  egress byte ends a packet.
REQ-012 m_err  output  1  egress entry is a truncation marker; m_last SHALL also be 1 and m_data SHALL be 0x00.
REQ-013 m_ready  input  1  downstream accepts the head entry.
REQ-014 overflow  output  1  sticky flag: at least one payload byte was lost.

Function
REQ-015 Push condition SHALL be data_valid_in && fwd_enable && !drop_enable in state PASS; drop_enable SHALL win when both enables are high.
REQ-016 Each entry SHALL store {err, last, data}, with last = last_in.
REQ-017 Pop SHALL occur when m_valid && m_ready; m_valid SHALL be !empty; m_data/m_last/m_err SHALL come from the head entry with zero added latency; push-to-m_valid latency is 1 cycle.
REQ-018 Full with a simultaneous pop SHALL accept the push; empty with a simultaneous push SHALL NOT bypass, so m_valid rises the next cycle.
REQ-019 Pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH, and derive full/empty from the MSB compare.
REQ-020 The state machine SHALL have states PASS, TRUNC, and MARK; it resets to PASS.
REQ-021 PASS -> TRUNC: push condition true, FIFO full, no pop this cycle, last_in=0; the byte is discarded and overflow is set.
REQ-022 PASS -> MARK: same as REQ-021 but with last_in=1.
REQ-023 TRUNC: all bytes are discarded; on data_valid_in && last_in, go to MARK.
REQ-024 MARK: write marker {1,1,0x00} on the first cycle the FIFO is not full or pops, then go to PASS; data_valid_in bytes arriving in MARK are discarded and overflow is set.
REQ-025 Bytes with data_valid_in=1 and both enables low, or with drop_enable=1, SHALL be discarded without side effects.
REQ-026 The block SHALL NOT reorder entries; the marker SHALL follow all previously stored bytes of the truncated packet.

Reset
REQ-027 rst_n low SHALL immediately clear the pointers, state (PASS), overflow, and statistics counters; m_valid, m_last, and m_err SHALL read 0 while in reset.
REQ-028 Reset mid-packet SHALL discard the FIFO contents; no marker is generated.
REQ-029 Reset deassertion SHALL be used synchronously to clk.

Configuration
REQ-030 Macro FWD_STATS_EN defined: add outputs fwd_pkt_count[15:0], drop_pkt_count[15:0], and fwd_byte_count[31:0], all saturating.
REQ-031 fwd_pkt_count SHALL increment on each pushed last entry, including markers.
REQ-032 drop_pkt_count SHALL increment on data_valid_in && last_in && drop_enable.
REQ-033 fwd_byte_count SHALL increment on each pushed non-marker entry.
REQ-034 Macro absent: these ports and counters SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-035 Forward 5 bytes 0x11..0x15 (last on 0x15) with m_ready=1 -> same bytes emitted in order, m_last only on 0x15, m_err=0, overflow=0.
REQ-036 drop_enable and fwd_enable both high for 4 bytes -> nothing emitted, drop_pkt_count=1 (FWD_STATS_EN).
REQ-037 m_ready=0 and 10-byte forwarded packet, FIFO_DEPTH=8 -> first 8 bytes stored, overflow=1, after m_ready=1 get 8 bytes then marker {err=1, last=1, 0x00}.
REQ-038 FIFO full and a push with simultaneous pop in the same cycle -> push accepted, overflow stays 0, level stays 8.
REQ-039 rst_n pulsed low with 3 entries queued -> m_valid=0 immediately; next packet of 2 bytes emitted cleanly and counters restart from 0.
